// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, IF_BUSY, LSU_BUSY} arb_state_e;
  typedef enum logic       {OWN_IF, OWN_LSU}          arb_owner_e;

  localparam int DEF_ADDR_W        = 32;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_MAX_LSU_BURST = 4;
  localparam int DEF_TIMEOUT       = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter; expires in the TIMEOUT-th enabled cycle since the last clear.
module arb_watchdog #(
  parameter int TIMEOUT = 255
)(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign o_expire = i_en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                cnt_q <= '0;
    else if (i_clr)              cnt_q <= '0;
    else if (i_en && !o_expire)  cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and LSU; one transaction in flight,
// LSU priority bounded by MAX_LSU_BURST, watchdog abort on missing ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_LSU_BURST = DEF_MAX_LSU_BURST,
  parameter int TIMEOUT       = DEF_TIMEOUT
)(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_rvalid,
  output logic              o_if_stall,
  input  logic              i_lsu_req,
  input  logic              i_lsu_we,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic [3:0]        i_lsu_bmask,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic              o_lsu_rvalid,
  output logic              o_lsu_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_err
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        bmask;
  } mem_cmd_t;

  arb_state_e  state_q, state_d;
  arb_owner_e  owner;
  mem_cmd_t    cmd_q;
  logic [3:0]  burst_q;
  logic        mem_req_q, drop_q;
  logic        grant_if, grant_lsu, expire, done, if_kill;
  logic [DATA_W-1:0] rsp_data;

  assign owner    = (state_q == LSU_BUSY) ? OWN_LSU : OWN_IF;
  assign done     = (state_q != IDLE) && (i_mem_ack || expire);
  assign if_kill  = drop_q || i_if_flush;
  // A watchdog abort returns zero data to the owner.
  assign rsp_data = i_mem_ack ? i_mem_rdata : '0;

  always_comb begin
    state_d   = state_q;
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_lsu_req && (!i_if_req || burst_q < 4'(MAX_LSU_BURST))) begin
          grant_lsu = 1'b1;
          state_d   = LSU_BUSY;
        end else if (i_if_req && !i_if_flush) begin
          grant_if  = 1'b1;
          state_d   = IF_BUSY;
        end
      end
      IF_BUSY, LSU_BUSY: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (grant_if || grant_lsu),
    .i_en     (state_q != IDLE),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      mem_req_q <= 1'b0;
      cmd_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Burst count only tracks LSU wins while fetch is actually waiting.
      if (state_q == IDLE) begin
        if (grant_if || !i_if_req)            burst_q <= '0;
        else if (grant_lsu && burst_q != 4'hF) burst_q <= burst_q + 4'd1;
      end
      if (grant_lsu) begin
        mem_req_q <= 1'b1;
        cmd_q     <= '{we: i_lsu_we, addr: i_lsu_addr, wdata: i_lsu_wdata, bmask: i_lsu_bmask};
      end else if (grant_if) begin
        mem_req_q <= 1'b1;
        cmd_q     <= '{we: 1'b0, addr: i_if_addr, wdata: '0, bmask: 4'hF};
      end else if (done) begin
        mem_req_q <= 1'b0;
      end
      if (grant_if || grant_lsu || done)            drop_q <= 1'b0;
      else if (state_q == IF_BUSY && i_if_flush)    drop_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_if_rvalid  <= 1'b0;
      o_lsu_rvalid <= 1'b0;
      o_if_rdata   <= '0;
      o_lsu_rdata  <= '0;
      o_err        <= 1'b0;
    end else begin
      o_if_rvalid  <= done && owner == OWN_IF && !if_kill;
      o_lsu_rvalid <= done && owner == OWN_LSU;
      o_err        <= done && !i_mem_ack;
      if (done && owner == OWN_IF && !if_kill) o_if_rdata  <= rsp_data;
      if (done && owner == OWN_LSU)            o_lsu_rdata <= rsp_data;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = cmd_q.we;
  assign o_mem_addr  = cmd_q.addr;
  assign o_mem_wdata = cmd_q.wdata;
  assign o_mem_bmask = cmd_q.bmask;

  assign o_if_stall  = i_if_req && !o_if_rvalid;
  assign o_lsu_stall = i_lsu_req && !o_lsu_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester expected-data queues, a latency-programmable memory model.
module tb_mem_port_arbiter;

  localparam int AW = 32, DW = 32, MB = 4, TO = 8;

  logic          i_clk = 1'b0, i_reset = 1'b0;
  logic          i_if_req = 0, i_if_flush = 0, i_lsu_req = 0, i_lsu_we = 0, i_mem_ack = 0;
  logic [AW-1:0] i_if_addr = '0, i_lsu_addr = '0;
  logic [DW-1:0] i_lsu_wdata = '0, i_mem_rdata = '0;
  logic [3:0]    i_lsu_bmask = '0;
  logic [DW-1:0] o_if_rdata, o_lsu_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_bmask;
  logic          o_if_rvalid, o_if_stall, o_lsu_rvalid, o_lsu_stall, o_mem_req, o_mem_we, o_err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LSU_BURST(MB), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_rdata(o_if_rdata), .o_if_rvalid(o_if_rvalid), .o_if_stall(o_if_stall),
    .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_bmask(i_lsu_bmask),
    .o_lsu_rdata(o_lsu_rdata), .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_stall(o_lsu_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] sb_if[$], sb_lsu[$];
  int grant_log[$];
  int if_rv_cnt = 0;
  int ack_lat = 0, lat_cnt = 0;
  bit no_ack = 0;
  logic req_d = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h140: return 32'hCAFEF00D;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  // Memory: ack in the (ack_lat+1)-th cycle of o_mem_req, data keyed by address.
  always @(negedge i_clk) begin
    if (o_mem_req && !no_ack && lat_cnt == ack_lat) begin
      i_mem_ack   = 1'b1;
      i_mem_rdata = data_of(o_mem_addr);
    end else begin
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
    end
    lat_cnt = o_mem_req ? lat_cnt + 1 : 0;
  end

  // Response scoreboard and grant-order log (addr bit 13 marks LSU traffic).
  always @(negedge i_clk) begin
    if (o_if_rvalid) begin
      if_rv_cnt++;
      if (sb_if.size() == 0) chk("if_unexpected_rvalid", 1, 0);
      else                   chk("if_rdata", o_if_rdata, sb_if.pop_front());
    end
    if (o_lsu_rvalid) begin
      if (sb_lsu.size() == 0) chk("lsu_unexpected_rvalid", 1, 0);
      else                    chk("lsu_rdata", o_lsu_rdata, sb_lsu.pop_front());
    end
    if (o_mem_req && !req_d) grant_log.push_back(int'(o_mem_addr[13]));
    req_d <= o_mem_req;
  end

  // One request from fetch or LSU; returns negedges to rvalid, busy cycles seen, o_err at rvalid.
  task automatic xact(input bit lsu, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] bm, input logic [31:0] exp,
                      output int lat, output int busy, output bit err);
    bit rv, st;
    lat = 0; busy = 0; err = 0;
    if (lsu) begin
      i_lsu_req = 1; i_lsu_we = we; i_lsu_addr = a; i_lsu_wdata = wd; i_lsu_bmask = bm;
      sb_lsu.push_back(exp);
    end else begin
      i_if_req = 1; i_if_addr = a;
      sb_if.push_back(exp);
    end
    for (int n = 1; n <= 60; n++) begin
      @(negedge i_clk);
      if (o_mem_req && o_mem_addr[13] == lsu) begin
        busy++;
        chk("mem_addr", o_mem_addr, a);
        chk("mem_we", o_mem_we, we);
        if (lsu) begin
          chk("mem_wdata", o_mem_wdata, wd);
          chk("mem_bmask", o_mem_bmask, bm);
        end
      end
      rv = lsu ? o_lsu_rvalid : o_if_rvalid;
      st = lsu ? o_lsu_stall : o_if_stall;
      if (rv) begin
        lat = n; err = o_err;
        chk("stall_at_rvalid", st, 0);
        if (lsu) i_lsu_req = 0; else i_if_req = 0;
        return;
      end
      if (n == 1) chk("stall_waiting", st, 1);
    end
    chk("rvalid_timeout", 0, 1);
    if (lsu) i_lsu_req = 0; else i_if_req = 0;
  endtask

  int lat, busy, la, ba, lb, bb, rv0;
  bit err, ea, eb;
  int exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_if_rvalid", o_if_rvalid, 0);
    chk("rst_lsu_rvalid", o_lsu_rvalid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_addr", o_mem_addr, 0);
    i_reset = 1;
    @(negedge i_clk);

    // Fetch read, ack three cycles after o_mem_req rises
    ack_lat = 3;
    xact(0, 0, 32'h100, 0, 0, 32'hDEADBEEF, lat, busy, err);
    chk("t1_lat", lat, 5);
    chk("t1_busy", busy, 4);
    chk("t1_err", err, 0);

    // LSU write with immediate ack: minimum round trip
    ack_lat = 0;
    xact(1, 1, 32'h2000, 32'h12345678, 4'hF, data_of(32'h2000), lat, busy, err);
    chk("t2_lat", lat, 2);
    chk("t2_busy", busy, 1);

    // Both requesting continuously: LSU burst limit
    @(negedge i_clk);
    grant_log.delete();
    fork
      for (int i = 0; i < 8; i++)
        xact(1, 0, 32'h2100 + 32'(4*i), 0, 4'h3, data_of(32'h2100 + 32'(4*i)), la, ba, ea);
      for (int j = 0; j < 2; j++)
        xact(0, 0, 32'h400 + 32'(4*j), 0, 0, data_of(32'h400 + 32'(4*j)), lb, bb, eb);
    join
    chk("t3_grant_count", grant_log.size(), 10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++) chk("t3_grant_order", grant_log[k], exp_ord[k]);

    // Flush mid-transaction: bus completes, no fetch rvalid
    @(negedge i_clk);
    ack_lat = 3; rv0 = if_rv_cnt;
    i_if_req = 1; i_if_addr = 32'h140;
    repeat (2) @(negedge i_clk);
    chk("t4_busy", o_mem_req, 1);
    i_if_flush = 1; i_if_req = 0;
    @(negedge i_clk);
    i_if_flush = 0;
    for (int n = 0; n < 20 && o_mem_req; n++) @(negedge i_clk);
    chk("t4_bus_done", o_mem_req, 0);
    repeat (2) @(negedge i_clk);
    chk("t4_no_rvalid", if_rv_cnt - rv0, 0);

    // Flush in the same cycle as the ack
    ack_lat = 2; rv0 = if_rv_cnt;
    i_if_req = 1; i_if_addr = 32'h180;
    repeat (3) @(negedge i_clk);
    i_if_flush = 1; i_if_req = 0;
    #1 chk("t4b_ack_with_flush", i_mem_ack, 1);
    @(negedge i_clk);
    i_if_flush = 0;
    repeat (3) @(negedge i_clk);
    chk("t4b_no_rvalid", if_rv_cnt - rv0, 0);

    // Next fetch after a flush is served normally
    ack_lat = 1;
    xact(0, 0, 32'h1C0, 0, 0, data_of(32'h1C0), lat, busy, err);
    chk("t4c_lat", lat, 3);

    // Watchdog: no ack, abort after TIMEOUT busy cycles
    @(negedge i_clk);
    no_ack = 1;
    xact(1, 0, 32'h2200, 0, 4'h1, 32'h0, lat, busy, err);
    chk("t5_busy", busy, TO);
    chk("t5_lat", lat, TO + 1);
    chk("t5_err", err, 1);
    @(negedge i_clk);
    chk("t5_err_pulse", o_err, 0);
    chk("t5_mem_req", o_mem_req, 0);

    // Reset while LSU_BUSY
    i_lsu_req = 1; i_lsu_we = 1; i_lsu_addr = 32'h2300; i_lsu_wdata = 32'h55AA55AA; i_lsu_bmask = 4'hC;
    repeat (3) @(negedge i_clk);
    chk("t6_busy", o_mem_req, 1);
    i_reset = 0;
    #1;
    chk("t6_mem_req", o_mem_req, 0);
    chk("t6_mem_we", o_mem_we, 0);
    chk("t6_mem_addr", o_mem_addr, 0);
    chk("t6_mem_wdata", o_mem_wdata, 0);
    chk("t6_lsu_rvalid", o_lsu_rvalid, 0);
    chk("t6_err", o_err, 0);
    i_lsu_req = 0;
    @(negedge i_clk);
    i_reset = 1; no_ack = 0; ack_lat = 0;
    @(negedge i_clk);
    xact(1, 0, 32'h2340, 0, 4'hF, data_of(32'h2340), lat, busy, err);
    chk("t6_fresh_lat", lat, 2);

    repeat (2) @(negedge i_clk);
    chk("sb_if_empty", sb_if.size(), 0);
    chk("sb_lsu_empty", sb_lsu.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
